spi_frm_engine: RTL and testbench

//  SCLK-domain SPI slave frame engine, mode 0 (sample posedge, drive negedge), MSB first.

---
 rtl/spi_frm_pkg.sv | 40 ++++
 rtl/spi_frm_engine_if.sv | 23 ++
 rtl/spi_crc_ser.sv | 39 +++
 rtl/spi_frm_engine.sv | 155 +++++++++++++++
 tb/tb_spi_frm_engine.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_frm_pkg.sv
// rtl/spi_frm_pkg.sv - shared constants, frame state type and CRC helpers for the SPI frame engine
// Purpose: field widths, CRC polynomial/seed, frame FSM state type, serial and word CRC functions.
// Ports: none (package).
package spi_frm_pkg;

  localparam int CMD_W   = 8;
  localparam int DATA_W  = 8;
  localparam int CRC_W   = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
  localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;

  localparam int FRAME_W = CMD_W + DATA_W + CRC_W;
  localparam int PLD_W   = CMD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    S_CMD  = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2
  } frm_state_e;

  // One MSB-first CRC step; the polynomial's top bit is implicit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc, input logic din);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  // CRC over a full command+data payload, MSB first, from the frame seed.
  function automatic logic [CRC_W-1:0] crc_word(input logic [PLD_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = CRC_INIT;
    for (int i = PLD_W - 1; i >= 0; i--) begin
      c = crc_step(c, data[i]);
    end
    crc_word = c;
  endfunction

endpackage

// File: rtl/spi_frm_engine_if.sv
// rtl/spi_frm_engine_if.sv - SPI pad bundle between bus master and frame engine
// Purpose: groups chip select, MOSI and MISO of one SPI link.
// Ports: i_spi_csb (active-low select), i_spi_mosi (master data), o_spi_miso (slave data).
// Modports: master drives csb/mosi and reads miso; slave is the frame engine.
interface spi_frm_engine_if;

  logic i_spi_csb;
  logic i_spi_mosi;
  logic o_spi_miso;

  modport master (
    output i_spi_csb,
    output i_spi_mosi,
    input  o_spi_miso
  );

  modport slave (
    input  i_spi_csb,
    input  i_spi_mosi,
    output o_spi_miso
  );

endinterface

// File: rtl/spi_crc_ser.sv
// rtl/spi_crc_ser.sv - serial CRC register with seed-load and step enable
// Purpose: accumulates an MSB-first CRC one bit per clock.
// Ports: i_clk, i_rst_n (async active-low), i_load (seed and absorb i_bit),
//        i_en (absorb i_bit into running value), i_bit, o_crc (current remainder).
module spi_crc_ser
  import spi_frm_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;

  // Load folds the first bit in directly so no cycle is spent on the seed.
  always_comb begin
    crc_d = crc_q;
    if (i_load) begin
      crc_d = crc_step(CRC_INIT, i_bit);
    end else if (i_en) begin
      crc_d = crc_step(crc_q, i_bit);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/spi_frm_engine.sv
// rtl/spi_frm_engine.sv - SCLK-domain SPI mode-0 slave frame engine with burst and pipelined response
// Purpose: deserialises cmd/data/crc frames MSB first, checks the CRC, hands each frame to the
//          controller by toggle flag plus held data, and shifts the previous frame's response on MISO.
// Ports: i_spi_sclk (only clock), i_rst_n (async active-low), spi (slave modport: csb/mosi/miso),
//        i_rsp_pld (response payload), o_rx_cmd, o_rx_data, o_crc_ok, o_frm_tgl, o_burst_idx.
// Build option: SPI_RSP_CRC_EN appends a CRC of i_rsp_pld to the response; otherwise zeros.
module spi_frm_engine
  import spi_frm_pkg::*;
(
  input  logic              i_spi_sclk,
  input  logic              i_rst_n,
  spi_frm_engine_if.slave   spi,
  input  logic [PLD_W-1:0]  i_rsp_pld,
  output logic [CMD_W-1:0]  o_rx_cmd,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_crc_ok,
  output logic              o_frm_tgl,
  output logic [IDX_W-1:0]  o_burst_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PLD_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic csb;
  logic mosi;
  logic win_rst_n;

  frm_state_e         state_q,     state_d;
  logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic               new_win_q,   new_win_d;
  logic [CNT_W-1:0]   tx_ptr_q,    tx_ptr_d;
  logic [FRAME_W-2:0] rx_sr_q,     rx_sr_d;
  logic [CMD_W-1:0]   rx_cmd_q,    rx_cmd_d;
  logic [DATA_W-1:0]  rx_data_q,   rx_data_d;
  logic               crc_ok_q,    crc_ok_d;
  logic               frm_tgl_q,   frm_tgl_d;
  logic [IDX_W-1:0]   burst_idx_q, burst_idx_d;
  logic [FRAME_W-1:0] rsp_q,       rsp_d;

  logic               frame_end;
  logic [FRAME_W-1:0] frame_w;
  logic [CRC_W-1:0]   rx_crc;
  logic [CRC_W-1:0]   rsp_crc;

  assign csb  = spi.i_spi_csb;
  assign mosi = spi.i_spi_mosi;

  // Framing state lives only while CSB is low; a deselect restarts the frame.
  assign win_rst_n = i_rst_n & ~csb;

  assign frame_end = (bit_cnt_q == CNT_LAST);
  assign frame_w   = {rx_sr_q, mosi};

  spi_crc_ser u_rx_crc (
    .i_clk   (i_spi_sclk),
    .i_rst_n (i_rst_n),
    .i_load  (bit_cnt_q == '0),
    .i_en    (state_q != S_CRC),
    .i_bit   (mosi),
    .o_crc   (rx_crc)
  );

`ifdef SPI_RSP_CRC_EN
  assign rsp_crc = crc_word(i_rsp_pld);
`else
  assign rsp_crc = '0;
`endif

  always_comb begin
    bit_cnt_d = frame_end ? '0 : bit_cnt_q + 1'b1;
    new_win_d = frame_end ? 1'b0 : new_win_q;
    state_d   = state_q;
    case (state_q)
      S_CMD:   if (bit_cnt_q == CMD_LAST)  state_d = S_DATA;
      S_DATA:  if (bit_cnt_q == DATA_LAST) state_d = S_CRC;
      S_CRC:   if (frame_end)              state_d = S_CMD;
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge i_spi_sclk or negedge win_rst_n) begin
    if (!win_rst_n) begin
      state_q   <= S_CMD;
      bit_cnt_q <= '0;
      new_win_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      new_win_q <= new_win_d;
    end
  end

  always_comb begin
    rx_sr_d     = {rx_sr_q[FRAME_W-3:0], mosi};
    rx_cmd_d    = rx_cmd_q;
    rx_data_d   = rx_data_q;
    crc_ok_d    = crc_ok_q;
    frm_tgl_d   = frm_tgl_q;
    burst_idx_d = burst_idx_q;
    rsp_d       = rsp_q;
    if (frame_end) begin
      rx_cmd_d    = frame_w[FRAME_W-1 -: CMD_W];
      rx_data_d   = frame_w[CRC_W +: DATA_W];
      crc_ok_d    = (rx_crc == frame_w[CRC_W-1:0]);
      frm_tgl_d   = ~frm_tgl_q;
      // The first frame of a window restarts the index rather than counting on.
      burst_idx_d = new_win_q ? IDX_ONE :
                    (&burst_idx_q ? burst_idx_q : burst_idx_q + 1'b1);
      rsp_d       = {i_rsp_pld, rsp_crc};
    end
  end

  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_sr_q     <= '0;
      rx_cmd_q    <= '0;
      rx_data_q   <= '0;
      crc_ok_q    <= 1'b0;
      frm_tgl_q   <= 1'b0;
      burst_idx_q <= '0;
      rsp_q       <= '0;
    end else begin
      rx_sr_q     <= rx_sr_d;
      rx_cmd_q    <= rx_cmd_d;
      rx_data_q   <= rx_data_d;
      crc_ok_q    <= crc_ok_d;
      frm_tgl_q   <= frm_tgl_d;
      burst_idx_q <= burst_idx_d;
      rsp_q       <= rsp_d;
    end
  end

  // Pointer sits on the MSB while deselected so MISO is valid at CSB fall;
  // its wrap lines up with the frame-end reload of rsp_q.
  assign tx_ptr_d = (tx_ptr_q == '0) ? CNT_LAST : tx_ptr_q - 1'b1;

  always_ff @(negedge i_spi_sclk or negedge win_rst_n) begin
    if (!win_rst_n) begin
      tx_ptr_q <= CNT_LAST;
    end else begin
      tx_ptr_q <= tx_ptr_d;
    end
  end

  assign spi.o_spi_miso = rsp_q[tx_ptr_q];

  assign o_rx_cmd    = rx_cmd_q;
  assign o_rx_data   = rx_data_q;
  assign o_crc_ok    = crc_ok_q;
  assign o_frm_tgl   = frm_tgl_q;
  assign o_burst_idx = burst_idx_q;

endmodule

// File: tb/tb_spi_frm_engine.sv
// tb/tb_spi_frm_engine.sv - self-checking bench for the SPI frame engine
module tb_spi_frm_engine;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rsp_pld = 16'h0;
  logic [7:0]  rx_cmd;
  logic [7:0]  rx_data;
  logic        crc_ok;
  logic        frm_tgl;
  logic [3:0]  burst_idx;

  spi_frm_engine_if bus ();

  spi_frm_engine dut (
    .i_spi_sclk  (sclk),
    .i_rst_n     (rst_n),
    .spi         (bus),
    .i_rsp_pld   (rsp_pld),
    .o_rx_cmd    (rx_cmd),
    .o_rx_data   (rx_data),
    .o_crc_ok    (crc_ok),
    .o_frm_tgl   (frm_tgl),
    .o_burst_idx (burst_idx)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  exp_cmd = 8'h0;
  logic [7:0]  exp_data = 8'h0;
  logic        exp_ok = 1'b0;
  logic        exp_tgl = 1'b0;
  logic [3:0]  exp_idx = 4'h0;
  logic [23:0] exp_rsp = 24'h0;
  int          win_cnt = 0;

  // CRC as remainder of the augmented message divided by x^8+x^2+x+1 (seed 0).
  function automatic logic [7:0] tb_crc(input logic [15:0] msg);
    logic [23:0] r;
    r = {msg, 8'h00};
    for (int i = 23; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".cmd"},  32'(rx_cmd),    32'(exp_cmd));
    chk({tag, ".data"}, 32'(rx_data),   32'(exp_data));
    chk({tag, ".ok"},   32'(crc_ok),    32'(exp_ok));
    chk({tag, ".tgl"},  32'(frm_tgl),   32'(exp_tgl));
    chk({tag, ".idx"},  32'(burst_idx), 32'(exp_idx));
  endtask

  task automatic shift(input logic [23:0] fr, input int n, output logic [23:0] mo);
    mo = '0;
    for (int i = 0; i < n; i++) begin
      bus.i_spi_mosi = fr[23-i];
      #5;
      mo[23-i] = bus.o_spi_miso;
      sclk = 1'b1;
      #5;
      sclk = 1'b0;
    end
    #5;
  endtask

  task automatic cs_low();
    bus.i_spi_csb = 1'b0;
    win_cnt = 0;
    #5;
  endtask

  task automatic cs_high();
    bus.i_spi_csb = 1'b1;
    #10;
  endtask

  task automatic frame(input logic [23:0] fr, input logic [15:0] pld, input string tag,
                       output logic [23:0] mo);
    logic [23:0] exp_mo;
    rsp_pld = pld;
    exp_mo = exp_rsp;
    shift(fr, 24, mo);
    win_cnt++;
    exp_cmd  = fr[23:16];
    exp_data = fr[15:8];
    exp_ok   = (fr[7:0] == tb_crc(fr[23:8]));
    exp_tgl  = ~exp_tgl;
    exp_idx  = (win_cnt > 15) ? 4'd15 : 4'(win_cnt);
`ifdef SPI_RSP_CRC_EN
    exp_rsp = {pld, tb_crc(pld)};
`else
    exp_rsp = {pld, 8'h00};
`endif
    chk({tag, ".miso"}, 32'(mo), 32'(exp_mo));
    check_outs(tag);
  endtask

  function automatic logic [23:0] mk(input logic [7:0] c, input logic [7:0] d, input logic bad);
    logic [7:0] k;
    k = tb_crc({c, d});
    if (bad) k = k ^ 8'(1 + $urandom_range(0, 254));
    return {c, d, k};
  endfunction

  initial begin
    logic [23:0] mo;
    logic [7:0]  c;
    logic [7:0]  exp6;
    int          n;

    bus.i_spi_csb = 1'b1;
    bus.i_spi_mosi = 1'b0;
    #10;
    check_outs("reset");
    chk("reset.miso", 32'(bus.o_spi_miso), 32'd0);
    rst_n = 1'b1;
    #10;

    // All-zero frame with zero seed carries a zero CRC.
    cs_low();
    frame(24'h000000, 16'h1234, "t1", mo);
    cs_high();
    check_outs("t1.hold");

    // Good and corrupted CRC on the same payload.
    c = spi_frm_pkg::crc_word(16'h853C);
    chk("t2.pkg_crc", 32'(c), 32'(tb_crc(16'h853C)));
    cs_low();
    frame({16'h853C, c}, 16'h5A5A, "t2.good", mo);
    frame({16'h853C, c ^ 8'h01}, 16'hC3C3, "t2.bad", mo);
    chk("t2.bad.ok", 32'(crc_ok), 32'd0);
    cs_high();

    // Three-frame burst with random payloads.
    cs_low();
    for (int i = 0; i < 3; i++) begin
      frame(mk(8'($urandom), 8'($urandom), 1'b0), 16'($urandom), "t3", mo);
    end
    cs_high();

    // Partial frame is dropped, following frame starts clean.
    cs_low();
    shift(24'($urandom), 13, mo);
    cs_high();
    check_outs("t4.partial");
    cs_low();
    frame(mk(8'h01, 8'hA5, 1'b0), 16'hBEEF, "t4.next", mo);
    chk("t4.next.idx", 32'(burst_idx), 32'd1);
    cs_high();

    // Reset in the middle of a frame.
    cs_low();
    shift(24'($urandom), 10, mo);
    rst_n = 1'b0;
    #2;
    exp_cmd = 8'h0; exp_data = 8'h0; exp_ok = 1'b0; exp_tgl = 1'b0; exp_idx = 4'h0;
    exp_rsp = 24'h0;
    win_cnt = 0;
    check_outs("t5.rst");
    chk("t5.rst.miso", 32'(bus.o_spi_miso), 32'd0);
    rst_n = 1'b1;
    #3;
    frame(mk(8'($urandom), 8'($urandom), 1'b0), 16'($urandom), "t5.after", mo);
    cs_high();

    // Response CRC field on MISO.
    cs_low();
    frame(mk(8'($urandom), 8'($urandom), 1'b0), 16'h8012, "t6.a", mo);
    frame(mk(8'($urandom), 8'($urandom), 1'b0), 16'h0000, "t6.b", mo);
`ifdef SPI_RSP_CRC_EN
    exp6 = tb_crc(16'h8012);
`else
    exp6 = 8'h00;
`endif
    chk("t6.rsp_crc", 32'(mo[7:0]), 32'(exp6));
    cs_high();

    // Random bursts with random CRC corruption.
    for (int b = 0; b < 4; b++) begin
      cs_low();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        frame(mk(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1))), 16'($urandom), "rnd", mo);
      end
      cs_high();
      check_outs("rnd.hold");
    end

    // Burst index saturation.
    cs_low();
    for (int i = 0; i < 17; i++) begin
      frame(mk(8'($urandom), 8'($urandom), 1'b0), 16'($urandom), "sat", mo);
    end
    chk("sat.idx", 32'(burst_idx), 32'd15);
    cs_high();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
